// File: rtl/eq_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eq_cmp_pkg
// Description : Shared definitions for the equality-comparator scheduler.
//               Provides the response-FSM state encoding and a clog2 helper
//               that never returns less than 1. The helper sizes ID fields
//               so they stay valid when there is only a single requester.
// Ports       : (package, no ports)
// Revision    : 1.0 - initial release
// ============================================================================
package eq_cmp_pkg;

  // Response-register occupancy: IDLE = empty, FULL = holding a result.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Smallest r >= 1 with 2**r >= n.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : eq_cmp_pkg
`default_nettype wire

// File: rtl/eq_cmp_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting at ptr and wrapping modulo NREQ. The first
//               set bit found is the winner. The grant is one-hot and is
//               forced to zero when en is low or when no request is set.
//               grant_id always reports the winning index, so the caller
//               can use it as a mux select even while the grant is gated
//               off.
// Ports       : req      [NREQ-1:0] in  request vector
//               ptr      [IDW-1:0]  in  highest-priority index this cycle
//               en       1          in  grant enable
//               grant    [NREQ-1:0] out one-hot grant, or zero
//               grant_id [IDW-1:0]  out index of the winning request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import eq_cmp_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic any_req;

  // Walk the offsets from farthest to nearest. The last hit is then the
  // closest request at or after ptr, which is the round-robin winner.
  always_comb begin
    int idx;
    idx      = 0;
    any_req  = 1'b0;
    grant_id = '0;
    grant    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        any_req  = 1'b1;
        grant_id = IDW'(idx);
      end
    end
    if (en && any_req) grant[grant_id] = 1'b1;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/eq_cmp_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : eq_cmp_scheduler
// Description : Shares one equality comparator among NREQ requesters.
//               A round-robin arbiter picks one requester per cycle and
//               muxes its operand pair into the comparator. The result
//               and the requester ID are registered into a one-deep
//               response slot. Free-running counters track accepted
//               comparisons and matches for debug.
// Ports       : clk          in  rising-edge clock
//               reset_n      in  asynchronous active-low reset
//               req_val      in  [NREQ]   per-requester valid
//               req_rdy      out [NREQ]   per-requester grant (one-hot/zero)
//               req_in0      in  [NREQ*W] operand A, requester i at [i*W +: W]
//               req_in1      in  [NREQ*W] operand B, same packing
//               resp_val     out response valid
//               resp_rdy     in  response consumer ready
//               resp_id      out [IDW]    requester that produced the response
//               resp_eq      out 1 when the operands were equal
//               cmp_count    out [CW]     accepted comparisons (wrapping)
//               match_count  out [CW]     accepted equal comparisons (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module eq_cmp_scheduler
  import eq_cmp_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int W    = 32,
  parameter  int CW   = 16,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [NREQ*W-1:0] req_in0,
  input  logic [NREQ*W-1:0] req_in1,
  output logic              resp_val,
  input  logic              resp_rdy,
  output logic [IDW-1:0]    resp_id,
  output logic              resp_eq,
  output logic [CW-1:0]     cmp_count,
  output logic [CW-1:0]     match_count
);

  state_e          state_q,       state_d;
  logic [IDW-1:0]  ptr_q,         ptr_d;
  logic [IDW-1:0]  resp_id_q,     resp_id_d;
  logic            resp_eq_q,     resp_eq_d;
  logic [CW-1:0]   cmp_count_q,   cmp_count_d;
  logic [CW-1:0]   match_count_q, match_count_d;

  logic            can_acc;
  logic            fire;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            is_eq;

  // A new result can be taken when the slot is empty, or when the held
  // result leaves this same cycle.
  assign can_acc = (state_q == ST_IDLE) || resp_rdy;

  rr_arbiter #(
    .NREQ     (NREQ)
  ) u_arb (
    .req      (req_val),
    .ptr      (ptr_q),
    .en       (can_acc),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_rdy = grant;
  assign fire    = |grant;

  // Single shared comparator on the winner's operands.
  assign op_a  = req_in0[int'(grant_id)*W +: W];
  assign op_b  = req_in1[int'(grant_id)*W +: W];
  assign is_eq = (op_a == op_b);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    resp_id_d     = resp_id_q;
    resp_eq_d     = resp_eq_q;
    cmp_count_d   = cmp_count_q;
    match_count_d = match_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fire) state_d = ST_FULL;
      end
      ST_FULL: begin
        // A consume without a replacement empties the slot. A consume with
        // a fire stays FULL, and the new result overwrites the old one.
        if (resp_rdy && !fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fire) begin
      resp_id_d   = grant_id;
      resp_eq_d   = is_eq;
      // The winner becomes lowest priority next cycle.
      ptr_d       = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      cmp_count_d = cmp_count_q + CW'(1);
      if (is_eq) match_count_d = match_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      resp_id_q     <= '0;
      resp_eq_q     <= 1'b0;
      cmp_count_q   <= '0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      resp_id_q     <= resp_id_d;
      resp_eq_q     <= resp_eq_d;
      cmp_count_q   <= cmp_count_d;
      match_count_q <= match_count_d;
    end
  end

  assign resp_val    = (state_q == ST_FULL);
  assign resp_id     = resp_id_q;
  assign resp_eq     = resp_eq_q;
  assign cmp_count   = cmp_count_q;
  assign match_count = match_count_q;

endmodule : eq_cmp_scheduler
`default_nettype wire
